// File: rtl/pipe_skid.sv
// Two-entry elastic pipeline stage: a main register feeding o_data and a skid
// register that absorbs one extra beat so o_ready never depends on i_ready.
module pipe_skid #(
    parameter int DATA_WIDTH        = 32,
    parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_xfer;
    logic                  out_xfer;

    // Ready is forced low during reset; otherwise it depends only on registered state.
    assign o_ready     = ~rst & (state_q != SKID);
    assign o_valid     = (state_q != EMPTY);
    assign o_data      = main_q;
    assign o_occupancy = state_q;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_CLEARS_DATA) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = i_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d = i_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = i_data;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid.sv
// Bench for pipe_skid: directed vector table plus a queue reference model that
// checks four instances (32-bit both flush modes, 1-bit, 64-bit) every cycle.
module tb_pipe_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;

    logic        a_ready, a_valid;
    logic [31:0] a_data;
    logic [1:0]  a_occ;
    logic        b_ready, b_valid;
    logic [31:0] b_data;
    logic [1:0]  b_occ;
    logic        c_ready, c_valid;
    logic [0:0]  c_data;
    logic [1:0]  c_occ;
    logic        d_ready, d_valid;
    logic [63:0] d_data;
    logic [1:0]  d_occ;

    logic [0:0]  i_data1;
    logic [63:0] i_data64;
    assign i_data1  = i_data[0:0];
    assign i_data64 = {i_data, i_data};

    pipe_skid #(.DATA_WIDTH(32), .FLUSH_CLEARS_DATA(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_ready(a_ready), .o_valid(a_valid), .o_data(a_data), .i_ready(i_ready),
        .o_occupancy(a_occ));

    pipe_skid #(.DATA_WIDTH(32), .FLUSH_CLEARS_DATA(1'b0)) u_fcd0 (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_ready(b_ready), .o_valid(b_valid), .o_data(b_data), .i_ready(i_ready),
        .o_occupancy(b_occ));

    pipe_skid #(.DATA_WIDTH(1), .FLUSH_CLEARS_DATA(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data1),
        .o_ready(c_ready), .o_valid(c_valid), .o_data(c_data), .i_ready(i_ready),
        .o_occupancy(c_occ));

    pipe_skid #(.DATA_WIDTH(64), .FLUSH_CLEARS_DATA(1'b1)) u_w64 (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data64),
        .o_ready(d_ready), .o_valid(d_valid), .o_data(d_data), .i_ready(i_ready),
        .o_occupancy(d_occ));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beats in flight, plus what main shows once empty.
    logic [31:0] sb_q[$];
    logic [31:0] hold1;
    logic [31:0] hold0;

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic        er;
        logic [1:0]  eo;
        logic [31:0] ed;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int          sz;
        logic [31:0] e1;
        logic [31:0] e0;
        logic        ev;
        logic        er;
        sz = sb_q.size();
        e1 = (sz > 0) ? sb_q[0] : hold1;
        e0 = (sz > 0) ? sb_q[0] : hold0;
        ev = (sz > 0);
        er = !rst && (sz < 2);
        chk("a_valid", 64'(a_valid), 64'(ev));
        chk("a_ready", 64'(a_ready), 64'(er));
        chk("a_occ",   64'(a_occ),   64'(sz));
        chk("a_data",  64'(a_data),  64'(e1));
        chk("b_valid", 64'(b_valid), 64'(ev));
        chk("b_ready", 64'(b_ready), 64'(er));
        chk("b_occ",   64'(b_occ),   64'(sz));
        chk("b_data",  64'(b_data),  64'(e0));
        chk("c_valid", 64'(c_valid), 64'(ev));
        chk("c_ready", 64'(c_ready), 64'(er));
        chk("c_occ",   64'(c_occ),   64'(sz));
        chk("c_data",  64'(c_data),  64'(e1[0]));
        chk("d_valid", 64'(d_valid), 64'(ev));
        chk("d_ready", 64'(d_ready), 64'(er));
        chk("d_occ",   64'(d_occ),   64'(sz));
        chk("d_data",  d_data,       {e1, e1});
    endtask

    // One clock: drive, score the output beat before the edge, update model, check.
    task automatic step(input logic f, input logic v, input logic [31:0] d, input logic r);
        logic in_x;
        logic out_x;
        flush   = f;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(negedge clk);
        in_x  = v && (sb_q.size() < 2);
        out_x = r && (sb_q.size() > 0);
        if (!f && out_x) chk("sb_out_data", 64'(a_data), 64'(sb_q[0]));
        @(posedge clk);
        if (f) begin
            sb_q.delete();
            hold1 = '0;
        end else begin
            if (out_x) void'(sb_q.pop_front());
            if (in_x) sb_q.push_back(d);
            if (sb_q.size() > 0) begin
                hold1 = sb_q[0];
                hold0 = sb_q[0];
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        sb_q.delete();
        hold1   = '0;
        hold0   = '0;
        rst     = 1'b1;
        flush   = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        i_ready = 1'b0;

        // Reset with a beat offered at the input
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_data",  64'(a_data),  64'd0);
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_occ",   64'(a_occ),   64'd0);
        check_all();
        @(negedge clk);
        i_valid = 1'b0;
        rst     = 1'b0;
        #1;
        chk("rel_ready", 64'(a_ready), 64'd1);
        check_all();

        //           fl    v     d       r     ev    er    eo     ed
        vecs.push_back('{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 2'd1, 32'h1});
        vecs.push_back('{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 2'd1, 32'h2});
        vecs.push_back('{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 2'd1, 32'h3});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h3});
        vecs.push_back('{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA});
        vecs.push_back('{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
        vecs.push_back('{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
        vecs.push_back('{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB});
        vecs.push_back('{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 2'd1, 32'hC});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hC});
        vecs.push_back('{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA});
        vecs.push_back('{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
        vecs.push_back('{1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 2'd1, 32'h5});
        vecs.push_back('{1'b1, 1'b1, 32'h6, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0});

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].fl, vecs[k].v, vecs[k].d, vecs[k].r);
            chk($sformatf("vec%0d_valid", k), 64'(a_valid), 64'(vecs[k].ev));
            chk($sformatf("vec%0d_ready", k), 64'(a_ready), 64'(vecs[k].er));
            chk($sformatf("vec%0d_occ", k),   64'(a_occ),   64'(vecs[k].eo));
            chk($sformatf("vec%0d_data", k),  64'(a_data),  64'(vecs[k].ed));
        end

        // Flush in SKID with the non-clearing variant keeps main's old value
        step(1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b1, 32'h33, 1'b0);
        chk("fcd0_flush_data", 64'(b_data), 64'h11);
        chk("fcd1_flush_data", 64'(a_data), 64'h0);

        // Async reset between edges while in SKID
        step(1'b0, 1'b1, 32'h44, 1'b0);
        step(1'b0, 1'b1, 32'h55, 1'b0);
        chk("pre_rst_occ", 64'(a_occ), 64'd2);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(a_valid), 64'd0);
        chk("arst_occ",   64'(a_occ),   64'd0);
        chk("arst_data",  64'(a_data),  64'd0);
        chk("arst_ready", 64'(a_ready), 64'd0);
        sb_q.delete();
        hold1 = '0;
        hold0 = '0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // Random traffic; the model checks ordering and every output each cycle
        for (int n = 0; n < 10000; n++) begin
            step(1'b0, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
        end
        // Drain whatever is left
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drained_occ", 64'(a_occ), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
